// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO read-side drain controller.
// Holds FIFO geometry, the controller state encoding and the skid-credit helper.
package fifo_drain_ctrl_pkg;

    localparam int unsigned FIFO_DW    = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    // A new read may issue only if the byte it returns still has a skid slot after this cycle's pop.
    function automatic logic skid_credit_ok(input logic [OCC_W-1:0] occ,
                                            input logic             inflight,
                                            input logic             pop);
        return (3'(occ) + 3'(inflight)) < (3'(SKID_DEPTH) + 3'(pop));
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_skid.sv
// Two-entry FIFO-ordered skid buffer; head entry and valid are driven straight from flops.
module fifo_drain_ctrl_skid
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned DW = FIFO_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic             m_valid,
    output logic [DW-1:0]    m_data
);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DW-1:0]    head_q, head_d;
    logic [DW-1:0]    tail_q, tail_d;
    logic             valid_q, valid_d;
    logic             pop_ok_c;

    assign pop_ok_c = pop && (occ_q != '0);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (clear) begin
            occ_d = '0;
        end else begin
            case ({push, pop_ok_c})
                2'b10: begin
                    if (occ_q == '0) begin
                        head_d = push_data;
                    end else begin
                        tail_d = push_data;
                    end
                    if (occ_q != OCC_W'(SKID_DEPTH)) begin
                        occ_d = occ_q + OCC_W'(1);
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - OCC_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; the new byte lands behind whatever stays.
                    if (occ_q == OCC_W'(1)) begin
                        head_d = push_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    assign occ     = occ_q;
    assign m_valid = valid_q;
    assign m_data  = head_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a requested number of bytes from the synchronous FIFO onto a valid/ready stream,
// hiding the FIFO read latency behind a two-entry skid buffer.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned DW = FIFO_DW,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] burst_len,
    input  logic          abort,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd_en,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] rd_count
);

    drain_state_e     state_q, state_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic [CW-1:0]    rd_count_q, rd_count_d;
    logic             inflight_q, inflight_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             rd_en_c;
    logic             pop_c;
    logic             push_c;
    logic             buf_clear_c;
    logic [OCC_W-1:0] occ;

    assign pop_c = m_valid && m_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_count_d  = rd_count_q;
        inflight_d  = 1'b0;
        rd_en_c     = 1'b0;
        push_c      = inflight_q;
        buf_clear_c = 1'b0;

        if (pop_c) begin
            rd_count_d = rd_count_q + CW'(1);
        end

        if (abort) begin
            // Drop everything already read; bytes delivered so far stay counted.
            state_d     = ST_IDLE;
            remaining_d = '0;
            push_c      = 1'b0;
            buf_clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rd_count_d = '0;
                        if (burst_len != '0) begin
                            state_d     = ST_RUN;
                            remaining_d = burst_len;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    rd_en_c = !reset && !fifo_empty && (remaining_q != '0) &&
                              skid_credit_ok(occ, inflight_q, pop_c);
                    if (rd_en_c) begin
                        remaining_d = remaining_q - CW'(1);
                        inflight_d  = 1'b1;
                        if (remaining_q == CW'(1)) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Finish once the buffer is empty after this edge and nothing is in flight.
                    if (!inflight_q && ((occ == '0) || ((occ == OCC_W'(1)) && pop_c))) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            rd_count_q  <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_count_q  <= rd_count_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    fifo_drain_ctrl_skid #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (buf_clear_c),
        .push      (push_c),
        .push_data (fifo_dout),
        .pop       (pop_c),
        .occ       (occ),
        .m_valid   (m_valid),
        .m_data    (m_data)
    );

    assign fifo_rd_en = rd_en_c;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: a queue-based FIFO model feeds the DUT and a
// stream monitor compares delivered bytes against the order they were written.
module tb_fifo_drain_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] burst_len;
    logic          abort;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] rd_count;

    fifo_drain_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // FIFO environment: registered read data and registered empty flag
    logic [7:0] fq[$];
    logic       wr_en    = 1'b0;
    logic [7:0] wr_data  = '0;
    logic       fifo_clr = 1'b0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor, sampled mid-cycle
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cnt = 0;
    int         rd_total = 0;
    int         outstanding = 0;
    int         viol_uf = 0;
    int         viol_credit = 0;
    int         viol_stable = 0;
    logic       mon_pop;
    logic       prev_stall = 1'b0;
    logic       prev_kill = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] out_q[$];
    int         pop_cyc[$];

    always @(negedge clk) begin
        cyc++;
        mon_pop = m_valid && m_ready;
        if (start && !busy && !done && !reset && !abort) start_cyc = cyc;
        if (done) done_cnt++;
        if (fifo_rd_en) rd_total++;
        if (fifo_rd_en && fifo_empty) viol_uf++;
        if (fifo_rd_en && (outstanding - int'(mon_pop)) >= 2) viol_credit++;
        if (prev_stall && !prev_kill && (!m_valid || m_data != prev_data)) viol_stable++;
        if (mon_pop) begin
            out_q.push_back(m_data);
            pop_cyc.push_back(cyc);
        end
        if (reset || abort) outstanding = 0;
        else outstanding = outstanding + int'(fifo_rd_en) - int'(mon_pop);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_kill  = reset || abort;
    end

    // m_ready policy: 0 low, 1 high, 2 toggle, 3 random
    int rmode = 1;

    task automatic step(input logic st, input logic [7:0] bl, input logic ab,
                        input logic we, input logic [7:0] wd);
        @(posedge clk);
        #1;
        start     = st;
        burst_len = bl;
        abort     = ab;
        wr_en     = we;
        wr_data   = wd;
        case (rmode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            idle(1);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, 32'(out_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    endtask

    logic [7:0] exp[$];
    logic [7:0] src[$];
    int         d0;
    int         r0;
    int         n;
    int         k;
    logic [7:0] b;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; burst_len = '0; m_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_reset_outputs("rst");

        // Full 16-byte burst with m_ready high: latency and throughput
        exp.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'hFF - 8'(i);
            step(1'b0, 8'd0, 1'b0, 1'b1, b);
            exp.push_back(b);
        end
        idle(2);
        out_q.delete(); pop_cyc.delete(); d0 = done_cnt; rmode = 1;
        step(1'b1, 8'd16, 1'b0, 1'b0, 8'd0);
        wait_done(100, "t1");
        idle(3);
        check_stream("t1", exp);
        if (pop_cyc.size() == 16) begin
            chk("t1_first_latency", 32'(pop_cyc[0] - start_cyc), 32'd3);
            chk("t1_last_latency", 32'(pop_cyc[15] - start_cyc), 32'd18);
        end
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t1_rd_count", 32'(rd_count), 32'd16);
        chk("t1_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // Same bytes with m_ready toggling
        for (int i = 0; i < 16; i++) step(1'b0, 8'd0, 1'b0, 1'b1, exp[i]);
        idle(2);
        out_q.delete(); rmode = 2;
        step(1'b1, 8'd16, 1'b0, 1'b0, 8'd0);
        wait_done(200, "t2");
        idle(2);
        check_stream("t2", exp);
        chk("t2_rd_count", 32'(rd_count), 32'd16);
        chk("t2_credit", 32'(viol_credit), 32'd0);
        chk("t2_stable", 32'(viol_stable), 32'd0);

        // FIFO runs dry mid-burst, then refills
        exp.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b1, 8'hA0 + 8'(i));
            exp.push_back(8'hA0 + 8'(i));
        end
        idle(2);
        out_q.delete(); rmode = 3;
        step(1'b1, 8'd6, 1'b0, 1'b0, 8'd0);
        k = 0;
        while (out_q.size() < 4 && k < 200) begin idle(1); k++; end
        idle(8);
        r0 = rd_total;
        idle(10);
        chk("t3_busy_wait", 32'(busy), 32'd1);
        chk("t3_no_read_empty", 32'(rd_total - r0), 32'd0);
        chk("t3_partial_len", 32'(out_q.size()), 32'd4);
        step(1'b0, 8'd0, 1'b0, 1'b1, 8'hA4);
        step(1'b0, 8'd0, 1'b0, 1'b1, 8'hA5);
        exp.push_back(8'hA4); exp.push_back(8'hA5);
        wait_done(200, "t3");
        idle(2);
        check_stream("t3", exp);
        chk("t3_rd_count", 32'(rd_count), 32'd6);

        // Zero-length burst
        rmode = 1; r0 = rd_total; out_q.delete();
        step(1'b1, 8'd0, 1'b0, 1'b0, 8'd0);
        idle(1);
        chk("t4_done_pulse", 32'(done), 32'd1);
        idle(1);
        chk("t4_done_gone", 32'(done), 32'd0);
        chk("t4_no_read", 32'(rd_total - r0), 32'd0);
        chk("t4_rd_count", 32'(rd_count), 32'd0);

        // Abort after five accepted bytes, then resume from what is left in the FIFO
        src.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            step(1'b0, 8'd0, 1'b0, 1'b1, b);
            src.push_back(b);
        end
        idle(2);
        out_q.delete(); rmode = 3;
        step(1'b1, 8'd16, 1'b0, 1'b0, 8'd0);
        k = 0;
        while (out_q.size() < 5 && k < 300) begin idle(1); k++; end
        rmode = 0; d0 = done_cnt;
        step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
        idle(1);
        chk("t5_m_valid_after_abort", 32'(m_valid), 32'd0);
        chk("t5_busy_after_abort", 32'(busy), 32'd0);
        chk("t5_rd_count_abort", 32'(rd_count), 32'd5);
        idle(5);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        exp.delete();
        for (int i = 0; i < 5; i++) exp.push_back(src[i]);
        check_stream("t5_pre", exp);
        chk("t5_fifo_left", 32'(fq.size() >= 8), 32'd1);
        if (fq.size() > 0) chk("t5_fifo_order", 32'(fq[0]), 32'(src[16 - fq.size()]));
        exp.delete();
        for (int i = 0; i < 8 && i < fq.size(); i++) exp.push_back(fq[i]);
        out_q.delete(); rmode = 3;
        step(1'b1, 8'd8, 1'b0, 1'b0, 8'd0);
        wait_done(300, "t5");
        idle(2);
        check_stream("t5_post", exp);
        chk("t5_rd_count", 32'(rd_count), 32'd8);
        fifo_clr = 1'b1; idle(1); fifo_clr = 1'b0; idle(1);

        // Reset mid-burst, then a burst with start held high throughout
        for (int i = 0; i < 16; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 8'($urandom));
        idle(2);
        rmode = 3;
        step(1'b1, 8'd16, 1'b0, 1'b0, 8'd0);
        idle(6);
        reset = 1'b1; fifo_clr = 1'b1;
        idle(2);
        reset = 1'b0; fifo_clr = 1'b0;
        idle(1);
        check_reset_outputs("t6_rst");
        exp.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b1, 8'h11 + 8'(i));
            exp.push_back(8'h11 + 8'(i));
        end
        idle(2);
        out_q.delete(); d0 = done_cnt; rmode = 1; k = 0;
        while (done_cnt == d0 && k < 100) begin
            step(1'b1, 8'd4, 1'b0, 1'b0, 8'd0);
            k++;
        end
        idle(10);
        chk("t6_single_done", 32'(done_cnt - d0), 32'd1);
        check_stream("t6", exp);
        chk("t6_rd_count", 32'(rd_count), 32'd4);

        // Random bursts with random backpressure
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 16);
            exp.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                step(1'b0, 8'd0, 1'b0, 1'b1, b);
                exp.push_back(b);
            end
            idle(2);
            out_q.delete(); rmode = 3;
            step(1'b1, 8'(n), 1'b0, 1'b0, 8'd0);
            wait_done(400, $sformatf("rnd%0d", it));
            idle(2);
            check_stream($sformatf("rnd%0d", it), exp);
            chk($sformatf("rnd%0d_rd_count", it), 32'(rd_count), 32'(n));
        end

        chk("underflow_reads", 32'(viol_uf), 32'd0);
        chk("credit_overrun", 32'(viol_credit), 32'd0);
        chk("stall_stability", 32'(viol_stable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
